// File: rtl/hzd_scoreboard.sv
// hzd_scoreboard: shift-register scoreboard of in-flight register writers. It produces forwarding
// selects for ID, a load-use stall and a bubble count. Define HZD_R0_ZERO_EN to hardwire register 0 to zero.
module hzd_scoreboard #(
  parameter int STAGES      = 3,
  parameter int NREGS       = 16,
  parameter int LOAD_READY  = 3,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic [$clog2(NREGS)-1:0]    id_rd1,
  input  logic [$clog2(NREGS)-1:0]    id_rd2,
  input  logic                        id_rd1_en,
  input  logic                        id_rd2_en,
  input  logic [$clog2(NREGS)-1:0]    id_wr,
  input  logic                        id_wr_en,
  input  logic                        id_load,
  output logic [$clog2(STAGES+1)-1:0] fwd1,
  output logic [$clog2(STAGES+1)-1:0] fwd2,
  output logic                        stall,
  output logic [15:0]                 bubbles
);
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(STAGES+1);

  logic          v_reg     [1:STAGES];
  logic [RW-1:0] wr_reg    [1:STAGES];
  logic          wr_en_reg [1:STAGES];
  logic          load_reg  [1:STAGES];
  logic [15:0]   bubbles_reg;

  logic rd1_used;
  logic rd2_used;
  logic wr_keep;

`ifdef HZD_R0_ZERO_EN
  assign rd1_used = id_rd1_en & (id_rd1 != '0);
  assign rd2_used = id_rd2_en & (id_rd2 != '0);
  assign wr_keep  = (id_wr != '0);
`else
  assign rd1_used = id_rd1_en;
  assign rd2_used = id_rd2_en;
  assign wr_keep  = 1'b1;
`endif

  logic [STAGES:1] match1;
  logic [STAGES:1] match2;
  logic [STAGES:1] not_ready;
  logic [STAGES:1] kill;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      // A load's data cannot be forwarded until it has reached LOAD_READY.
      localparam bit EARLY = (gi < LOAD_READY);
      // A flush kills the work currently held in stages 1..FLUSH_DEPTH.
      localparam bit KILLABLE = (gi <= FLUSH_DEPTH);
      assign match1[gi]    = rd1_used & v_reg[gi] & wr_en_reg[gi] & (wr_reg[gi] == id_rd1);
      assign match2[gi]    = rd2_used & v_reg[gi] & wr_en_reg[gi] & (wr_reg[gi] == id_rd2);
      assign not_ready[gi] = load_reg[gi] & EARLY;
      assign kill[gi]      = flush & KILLABLE;
    end
  endgenerate

  logic [SW-1:0] sel1;
  logic [SW-1:0] sel2;
  logic          lu1;
  logic          lu2;

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    lu1  = 1'b0;
    lu2  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (match1[k]) begin
        sel1 = SW'(k);
        lu1  = not_ready[k];
      end
      if (match2[k]) begin
        sel2 = SW'(k);
        lu2  = not_ready[k];
      end
    end
  end

  assign fwd1    = lu1 ? '0 : sel1;
  assign fwd2    = lu2 ? '0 : sel2;
  assign stall   = id_valid & (lu1 | lu2) & ~flush & ~hold;
  assign bubbles = bubbles_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) begin
        v_reg[k] <= 1'b0;
      end
      bubbles_reg <= '0;
    end else if (!hold) begin
      v_reg[1]     <= id_valid & ~stall & ~flush;
      wr_reg[1]    <= id_wr;
      wr_en_reg[1] <= id_wr_en & wr_keep;
      load_reg[1]  <= id_load;
      for (int k = 2; k <= STAGES; k++) begin
        v_reg[k]     <= v_reg[k-1] & ~kill[k-1];
        wr_reg[k]    <= wr_reg[k-1];
        wr_en_reg[k] <= wr_en_reg[k-1];
        load_reg[k]  <= load_reg[k-1];
      end
      if (stall && bubbles_reg != 16'hFFFF) begin
        bubbles_reg <= bubbles_reg + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_hzd_scoreboard.sv
// Testbench for hzd_scoreboard: directed scenarios plus randomized traffic checked
// against a list-of-in-flight-instructions reference model.
module tb_hzd_scoreboard;
  localparam int STAGES      = 3;
  localparam int NREGS       = 16;
  localparam int LOAD_READY  = 3;
  localparam int FLUSH_DEPTH = 1;
  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(STAGES+1);

  logic          clk = 1'b0;
  logic          rst, hold, flush, id_valid;
  logic [RW-1:0] id_rd1, id_rd2, id_wr;
  logic          id_rd1_en, id_rd2_en, id_wr_en, id_load;
  logic [SW-1:0] fwd1, fwd2;
  logic          stall;
  logic [15:0]   bubbles;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hzd_scoreboard #(
    .STAGES(STAGES), .NREGS(NREGS), .LOAD_READY(LOAD_READY), .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rd1_en(id_rd1_en), .id_rd2_en(id_rd2_en),
    .id_wr(id_wr), .id_wr_en(id_wr_en), .id_load(id_load),
    .fwd1(fwd1), .fwd2(fwd2), .stall(stall), .bubbles(bubbles)
  );

  // Reference model: pipe[a] is the instruction that has been in flight for a cycles.
  typedef struct {
    bit v;
    int wr;
    bit writes;
    bit load;
  } instr_t;
  instr_t pipe [1:STAGES];
  int     m_bubbles;

  function automatic bit r0_hardwired();
`ifdef HZD_R0_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Age of the most recent in-flight writer of rd, 0 if there is none.
  function automatic int producer_age(input bit used, input int rd);
    if (!used || (r0_hardwired() && rd == 0)) return 0;
    for (int a = 1; a <= STAGES; a++)
      if (pipe[a].v && pipe[a].writes && pipe[a].wr == rd) return a;
    return 0;
  endfunction

  function automatic void model_outputs(output int e1, output int e2, output bit est);
    int  a1, a2;
    bit  w1, w2;
    a1 = producer_age(id_rd1_en, int'(id_rd1));
    a2 = producer_age(id_rd2_en, int'(id_rd2));
    w1 = (a1 != 0) && pipe[a1].load && a1 < LOAD_READY;
    w2 = (a2 != 0) && pipe[a2].load && a2 < LOAD_READY;
    e1  = w1 ? 0 : a1;
    e2  = w2 ? 0 : a2;
    est = id_valid && (w1 || w2) && !flush && !hold;
  endfunction

  // Advance model by one clock using the inputs currently applied, then pass the edge.
  task automatic tick();
    int e1, e2;
    bit est;
    model_outputs(e1, e2, est);
    if (rst) begin
      for (int a = 1; a <= STAGES; a++) pipe[a].v = 1'b0;
      m_bubbles = 0;
    end else if (!hold) begin
      for (int a = STAGES; a >= 2; a--) begin
        pipe[a] = pipe[a-1];
        if (flush && (a - 1) <= FLUSH_DEPTH) pipe[a].v = 1'b0;
      end
      pipe[1] = '{id_valid && !est && !flush, int'(id_wr),
                  id_wr_en && !(r0_hardwired() && id_wr == '0), id_load};
      if (est && m_bubbles < 65535) m_bubbles++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int r1, input bit e1, input int r2, input bit e2,
                       input int w, input bit we, input bit ld);
    id_valid  = v;
    id_rd1    = RW'(r1);
    id_rd1_en = e1;
    id_rd2    = RW'(r2);
    id_rd2_en = e2;
    id_wr     = RW'(w);
    id_wr_en  = we;
    id_load   = ld;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < STAGES; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1; hold = 0; flush = 0;
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    tick(); tick();
    rst = 0;
    drive(1, 1, 1, 1, 1, 0, 0, 0);
    #1;
    n_cmp++; if (fwd1 !== '0) begin n_fail++; $display("FAIL reset_fwd1 got %0d want 0", fwd1); end
    n_cmp++; if (fwd2 !== '0) begin n_fail++; $display("FAIL reset_fwd2 got %0d want 0", fwd2); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_cmp++; if (bubbles !== 16'd0) begin n_fail++; $display("FAIL reset_bubbles got %0d want 0", bubbles); end
    $display("reset: fwd1=%0d fwd2=%0d stall=%0b bubbles=%0d", fwd1, fwd2, stall, bubbles);
    tick();
  endtask

  task automatic test_alu_chain();
    drain();
    drive(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0);
    for (int want = 1; want <= STAGES + 1; want++) begin
      int w;
      w = (want > STAGES) ? 0 : want;
      #1;
      n_cmp++; if (fwd1 !== SW'(w)) begin n_fail++; $display("FAIL alu_chain_fwd1 got %0d want %0d", fwd1, w); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_chain_stall got %0b want 0", stall); end
      $display("alu_chain: fwd1=%0d stall=%0b", fwd1, stall);
      tick();
    end
  endtask

  task automatic test_load_use();
    drain();
    drive(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall%0d got %0b want 1", c, stall); end
      n_cmp++; if (fwd2 !== '0) begin n_fail++; $display("FAIL load_use_fwd2_%0d got %0d want 0", c, fwd2); end
      $display("load_use: stall=%0b fwd2=%0d", stall, fwd2);
      tick();
    end
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got %0b want 0", stall); end
    n_cmp++; if (fwd2 !== SW'(3)) begin n_fail++; $display("FAIL load_use_fwd2 got %0d want 3", fwd2); end
    n_cmp++; if (bubbles !== 16'd2) begin n_fail++; $display("FAIL load_use_bubbles got %0d want 2", bubbles); end
    $display("load_use: stall=%0b fwd2=%0d bubbles=%0d", stall, fwd2, bubbles);
    tick();
  endtask

  task automatic test_youngest();
    drain();
    drive(1, 0, 0, 0, 0, 7, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 4, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 4, 1, 0); tick();
    drive(1, 4, 1, 7, 1, 0, 0, 0);
    #1;
    n_cmp++; if (fwd1 !== SW'(1)) begin n_fail++; $display("FAIL youngest_fwd1 got %0d want 1", fwd1); end
    n_cmp++; if (fwd2 !== SW'(3)) begin n_fail++; $display("FAIL two_port_fwd2 got %0d want 3", fwd2); end
    $display("youngest: fwd1=%0d fwd2=%0d", fwd1, fwd2);
    drive(1, 4, 1, 4, 1, 0, 0, 0);
    #1;
    n_cmp++; if (fwd2 !== SW'(1)) begin n_fail++; $display("FAIL same_reg_fwd2 got %0d want 1", fwd2); end
    $display("same_reg: fwd1=%0d fwd2=%0d", fwd1, fwd2);
    tick();
  endtask

  task automatic test_flush();
    drain();
    drive(1, 0, 0, 0, 0, 6, 1, 0); tick();
    flush = 1;
    drive(1, 0, 0, 0, 0, 9, 1, 0); tick();
    flush = 0;
    drive(1, 6, 1, 9, 1, 0, 0, 0);
    #1;
    n_cmp++; if (fwd1 !== '0) begin n_fail++; $display("FAIL flush_killed_fwd1 got %0d want 0", fwd1); end
    n_cmp++; if (fwd2 !== '0) begin n_fail++; $display("FAIL flush_bubble_fwd2 got %0d want 0", fwd2); end
    $display("flush: fwd1=%0d fwd2=%0d", fwd1, fwd2);
    tick();
    drain();
    drive(1, 0, 0, 0, 0, 5, 1, 1); tick();
    flush = 1;
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall got %0b want 0", stall); end
    tick();
    flush = 0;
    #1;
    n_cmp++; if (bubbles !== 16'd2) begin n_fail++; $display("FAIL flush_bubbles got %0d want 2", bubbles); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_load_killed got %0b want 0", stall); end
    $display("flush_load: stall=%0b bubbles=%0d", stall, bubbles);
    tick();
  endtask

  task automatic test_hold();
    drain();
    drive(1, 0, 0, 0, 0, 8, 1, 1); tick();
    hold = 1;
    drive(1, 8, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_stall%0d got %0b want 0", c, stall); end
      n_cmp++; if (bubbles !== 16'd2) begin n_fail++; $display("FAIL hold_bubbles%0d got %0d want 2", c, bubbles); end
      $display("hold: stall=%0b bubbles=%0d", stall, bubbles);
      tick();
    end
    hold = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_resume%0d got %0b want 1", c, stall); end
      $display("hold_release: stall=%0b", stall);
      tick();
    end
    #1;
    n_cmp++; if (fwd1 !== SW'(3)) begin n_fail++; $display("FAIL hold_fwd1 got %0d want 3", fwd1); end
    n_cmp++; if (bubbles !== 16'd4) begin n_fail++; $display("FAIL hold_total_bubbles got %0d want 4", bubbles); end
    tick();
  endtask

  task automatic test_r0();
    int w;
    drain();
    drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    w = r0_hardwired() ? 0 : 1;
    #1;
    n_cmp++; if (fwd1 !== SW'(w)) begin n_fail++; $display("FAIL r0_fwd1 got %0d want %0d", fwd1, w); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_stall got %0b want 0", stall); end
    $display("r0: fwd1=%0d stall=%0b", fwd1, stall);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
    rst = 1; tick();
    rst = 0;
    drive(1, 3, 1, 3, 1, 0, 0, 0);
    #1;
    n_cmp++; if (fwd1 !== '0) begin n_fail++; $display("FAIL reset_mid_fwd1 got %0d want 0", fwd1); end
    n_cmp++; if (bubbles !== 16'd0) begin n_fail++; $display("FAIL reset_mid_bubbles got %0d want 0", bubbles); end
    $display("reset_mid: fwd1=%0d bubbles=%0d", fwd1, bubbles);
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      int e1, e2;
      bit est;
      rst   = ($urandom_range(0, 59) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      #1;
      model_outputs(e1, e2, est);
      n_cmp++;
      if (fwd1 !== SW'(e1) || fwd2 !== SW'(e2) || stall !== est || bubbles !== 16'(m_bubbles)) begin
        n_fail++;
        $display("FAIL random_%0d got fwd1=%0d fwd2=%0d stall=%0b bubbles=%0d want %0d %0d %0b %0d",
                 t, fwd1, fwd2, stall, bubbles, e1, e2, est, m_bubbles);
      end else begin
        $display("txn %0d: rst=%0b hold=%0b flush=%0b v=%0b rd1=%0d/%0b rd2=%0d/%0b fwd1=%0d fwd2=%0d stall=%0b bubbles=%0d",
                 t, rst, hold, flush, id_valid, id_rd1, id_rd1_en, id_rd2, id_rd2_en, fwd1, fwd2, stall, bubbles);
      end
      tick();
    end
    rst = 0; hold = 0; flush = 0;
  endtask

  initial begin
    for (int a = 1; a <= STAGES; a++) pipe[a] = '{1'b0, 0, 1'b0, 1'b0};
    m_bubbles = 0;
    rst = 1; hold = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_flush();
    test_hold();
    test_r0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
